// File: rtl/am25ls_pkg.sv
// Shared constants for the am25ls up/down counter slice: count direction encodings
// and the default terminal value (all ones for a given width).
package am25ls_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Default MAXVAL: all ones of w bits. Callers cast the result to their own width.
  function automatic logic [63:0] all_ones(input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/am25ls_tcdet.sv
// Combinational terminal-count detector: up terminal at q==mod, down terminal at q==0,
// and the cascade carry/borrow gated by t and selected by the live direction.
module am25ls_tcdet
  import am25ls_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] mod,
  input  logic             t,
  input  logic             up,
  output logic             tc_up,
  output logic             tc_dn,
  output logic             co
);

  assign tc_up = (q == mod);
  assign tc_dn = (q == '0);
  assign co    = t & ((up == DIR_UP) ? tc_up : tc_dn);

endmodule

// File: rtl/am25ls_udcnt.sv
// Synchronous up/down counter slice with P/T enables, ripple carry and a one-cycle wrap
// pulse. Define AM25LS_MODULO_EN to add the loadable modulus register (mload_).
module am25ls_udcnt
  import am25ls_pkg::*;
#(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] MAXVAL = WIDTH'(all_ones(WIDTH))
) (
  input  logic             cp,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             load_,
  input  logic             mload_,
  input  logic             p,
  input  logic             t,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             wrap
);

  logic [WIDTH-1:0] mod;
  logic             tc_up;
  logic             tc_dn;

`ifdef AM25LS_MODULO_EN
  logic [WIDTH-1:0] mod_r;

  // The modulus load is independent of load_ and never blocks counting.
  always_ff @(posedge cp) begin
    if (clr) begin
      mod_r <= MAXVAL;
    end else if (!mload_) begin
      mod_r <= din;
    end
  end

  assign mod = mod_r;
`else
  logic unused_mload;

  assign mod          = MAXVAL;
  assign unused_mload = mload_;
`endif

  am25ls_tcdet #(
    .WIDTH(WIDTH)
  ) u_tcdet (
    .q    (q),
    .mod  (mod),
    .t    (t),
    .up   (up),
    .tc_up(tc_up),
    .tc_dn(tc_dn),
    .co   (co)
  );

  // A q above mod while counting up simply rolls through all ones to zero (no wrap pulse).
  always_ff @(posedge cp) begin
    if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (!load_) begin
      q    <= din;
      wrap <= 1'b0;
    end else if (p && t) begin
      if (up == DIR_UP) begin
        if (tc_up) begin
          q    <= '0;
          wrap <= 1'b1;
        end else begin
          q    <= q + 1'b1;
          wrap <= 1'b0;
        end
      end else begin
        if (tc_dn) begin
          q    <= mod;
          wrap <= 1'b1;
        end else begin
          q    <= q - 1'b1;
          wrap <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_am25ls_udcnt.sv
// Directed bench for am25ls_udcnt: an 8-bit slice plus two cascaded 4-bit slices.
// Modulus-specific vectors are selected by AM25LS_MODULO_EN.
module tb_am25ls_udcnt;

  logic       cp;
  logic       clr;
  logic [7:0] din;
  logic       load_;
  logic       mload_;
  logic       p;
  logic       t;
  logic       up;
  logic [7:0] q;
  logic       co;
  logic       wrap;

  logic [7:0] c_din;
  logic       c_load_;
  logic       c_mload_;
  logic       c_p;
  logic       c_up;
  logic       c_t;
  logic [3:0] q_lo;
  logic [3:0] q_hi;
  logic       co_lo;
  logic       co_hi;
  logic       wrap_lo;
  logic       wrap_hi;

  int n_vec;
  int n_err;

  // ---------------- clock / reset
  initial cp = 1'b0;
  always #5 cp = ~cp;

  am25ls_udcnt #(.WIDTH(8)) u_dut (
    .cp(cp), .clr(clr), .din(din), .load_(load_), .mload_(mload_),
    .p(p), .t(t), .up(up), .q(q), .co(co), .wrap(wrap)
  );

  am25ls_udcnt #(.WIDTH(4)) u_lo (
    .cp(cp), .clr(clr), .din(c_din[3:0]), .load_(c_load_), .mload_(c_mload_),
    .p(c_p), .t(c_t), .up(c_up), .q(q_lo), .co(co_lo), .wrap(wrap_lo)
  );

  am25ls_udcnt #(.WIDTH(4)) u_hi (
    .cp(cp), .clr(clr), .din(c_din[7:4]), .load_(c_load_), .mload_(c_mload_),
    .p(c_p), .t(co_lo), .up(c_up), .q(q_hi), .co(co_hi), .wrap(wrap_hi)
  );

  // ---------------- driver / checker tasks
  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_q(input logic [7:0] v);
    load_ = 1'b0;
    din   = v;
    tick();
    load_ = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clr = 1'b0; din = 8'h00; load_ = 1'b1; mload_ = 1'b1;
    p = 1'b0; t = 1'b0; up = 1'b1;
    c_din = 8'h00; c_load_ = 1'b1; c_mload_ = 1'b1; c_p = 1'b0; c_up = 1'b1; c_t = 1'b0;
    @(negedge cp);

    // Reset wins over a simultaneous load
    clr = 1'b1; load_ = 1'b0; din = 8'h55; t = 1'b1; up = 1'b0; p = 1'b1;
    tick();
    clr = 1'b0; load_ = 1'b1; p = 1'b0;
    check_val("rst_q", 32'(q), 32'h00);
    check_val("rst_wrap", 32'(wrap), 32'h0);
    check_val("rst_co_dn", 32'(co), 32'h1);
    up = 1'b1;
    #1;
    check_val("rst_co_up", 32'(co), 32'h0);

    // Up-count through the default terminal 0xFF
    load_q(8'hFD);
    check_val("ld_fd", 32'(q), 32'hFD);
    p = 1'b1; t = 1'b1; up = 1'b1;
    tick();
    check_val("up_fe", 32'(q), 32'hFE);
    check_val("up_fe_co", 32'(co), 32'h0);
    tick();
    check_val("up_ff", 32'(q), 32'hFF);
    check_val("up_ff_co", 32'(co), 32'h1);
    check_val("up_ff_wrap", 32'(wrap), 32'h0);
    up = 1'b0;
    #1;
    check_val("co_follows_up", 32'(co), 32'h0);
    up = 1'b1;
    tick();
    check_val("up_00", 32'(q), 32'h00);
    check_val("up_00_wrap", 32'(wrap), 32'h1);
    tick();
    check_val("up_01", 32'(q), 32'h01);
    check_val("up_01_wrap", 32'(wrap), 32'h0);

    // Down-count from zero reloads the terminal value
    p = 1'b0;
    load_q(8'h00);
    p = 1'b1; up = 1'b0;
    tick();
    check_val("dn_wrap_q", 32'(q), 32'hFF);
    check_val("dn_wrap", 32'(wrap), 32'h1);
    tick();
    check_val("dn_fe", 32'(q), 32'hFE);
    check_val("dn_fe_wrap", 32'(wrap), 32'h0);

    // Modulus register load (ignored when compiled out)
    p = 1'b0; up = 1'b1;
    mload_ = 1'b0; din = 8'd9;
    tick();
    mload_ = 1'b1;
    load_q(8'd7);
    p = 1'b1;
    tick();
    check_val("mod_q8", 32'(q), 32'd8);
    tick();
    check_val("mod_q9", 32'(q), 32'd9);
`ifdef AM25LS_MODULO_EN
    check_val("mod_q9_co", 32'(co), 32'h1);
    tick();
    check_val("mod_q0", 32'(q), 32'd0);
    check_val("mod_q0_wrap", 32'(wrap), 32'h1);
    tick();
    check_val("mod_q1", 32'(q), 32'd1);
    check_val("mod_q1_wrap", 32'(wrap), 32'h0);

    // Down-count with mod=9
    p = 1'b0;
    load_q(8'd1);
    p = 1'b1; up = 1'b0;
    tick();
    check_val("mdn_q0", 32'(q), 32'd0);
    check_val("mdn_q0_co", 32'(co), 32'h1);
    p = 1'b0; t = 1'b0;
    #1;
    check_val("mdn_t0_co", 32'(co), 32'h0);
    p = 1'b1; t = 1'b1;
    tick();
    check_val("mdn_q9", 32'(q), 32'd9);
    check_val("mdn_q9_wrap", 32'(wrap), 32'h1);
    tick();
    check_val("mdn_q8", 32'(q), 32'd8);
    check_val("mdn_q8_wrap", 32'(wrap), 32'h0);

    // Loaded above the modulus: roll through 0xFF to 0 without a wrap pulse
    p = 1'b0; up = 1'b1;
    load_q(8'hFE);
    p = 1'b1;
    tick();
    tick();
    check_val("above_mod_q", 32'(q), 32'h00);
    check_val("above_mod_wrap", 32'(wrap), 32'h0);
`else
    check_val("nomod_q9_co", 32'(co), 32'h0);
    tick();
    check_val("nomod_qa", 32'(q), 32'h0A);
    check_val("nomod_qa_wrap", 32'(wrap), 32'h0);
    tick();
    check_val("nomod_qb", 32'(q), 32'h0B);
`endif

    // Hold behaviour
    p = 1'b0; up = 1'b1;
    load_q(8'h42);
    t = 1'b1;
    tick();
    tick();
    check_val("hold_p0_q", 32'(q), 32'h42);
    check_val("hold_p0_wrap", 32'(wrap), 32'h0);
    p = 1'b1; t = 1'b0;
    tick();
    check_val("hold_t0_q", 32'(q), 32'h42);
    check_val("hold_t0_co", 32'(co), 32'h0);

    // Clear mid-count beats load and count
    t = 1'b1; clr = 1'b1; load_ = 1'b0; din = 8'hAA;
    tick();
    clr = 1'b0; load_ = 1'b1;
    check_val("clr_mid_q", 32'(q), 32'h00);
    check_val("clr_mid_wrap", 32'(wrap), 32'h0);

    // Two 4-bit slices cascaded through co -> t
    c_load_ = 1'b0; c_din = 8'h0E;
    tick();
    c_load_ = 1'b1; c_p = 1'b1; c_t = 1'b1; c_up = 1'b1;
    check_val("cas_ld", 32'({q_hi, q_lo}), 32'h0E);
    tick();
    check_val("cas_0f", 32'({q_hi, q_lo}), 32'h0F);
    check_val("cas_0f_co_lo", 32'(co_lo), 32'h1);
    tick();
    check_val("cas_10", 32'({q_hi, q_lo}), 32'h10);
    check_val("cas_10_wrap_lo", 32'(wrap_lo), 32'h1);
    check_val("cas_10_wrap_hi", 32'(wrap_hi), 32'h0);
    tick();
    check_val("cas_11", 32'({q_hi, q_lo}), 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/am25ls_udcnt.md
# am25ls_udcnt

Parametrised synchronous up/down counter, successor to the 4-bit '163-style counter slice in the model library. It adds programmable width, count direction, an optional programmable modulus (terminal-count) register with automatic wrap, and a registered one-cycle wrap pulse. It keeps the P/T enable and ripple-carry cascade semantics so that wide counters can still be built from several slices.

## Interface
- WIDTH, 4, counter and data width in bits (≥2).
- MAXVAL, 2**WIDTH-1, modulus register value after reset; when the modulo feature is compiled out, this is the fixed terminal value.

- cp  in  1  clock; every register updates on the rising edge.
- clr  in  1  reset; synchronous and active-high.
- din  in  WIDTH  parallel data for the count load and the modulus load.
- load_  in  1  active-low synchronous load of din into q.
- mload_  in  1  active-low synchronous load of din into the modulus register.
- p  in  1  count enable P (not cascaded).
- t  in  1  count enable T (cascaded); also gates co.
- up  in  1  direction: 1 counts up, 0 counts down.
- q  out  WIDTH  counter state.
- co  out  1  ripple carry/borrow; combinational.
- wrap  out  1  registered pulse, high for one cycle after a modulus wrap.

## Operation
- Priority on each rising cp edge: clr, then load_, then count, then hold.
- clr=1:
  - q<=0, mod<=MAXVAL, wrap<=0.
  - load_, mload_, p and t are ignored.
- load_=0: q<=din, wrap<=0, and no count in that cycle.
- mload_=0: mod<=din.
  - Independent of load_. If both are low, q and mod each take din.
  - mload_ does not inhibit counting.
- Count occurs when p&t=1 and load_=1.
  - up=1: if q==mod, q<=0 and wrap<=1. Otherwise q<=q+1, modulo 2**WIDTH.
  - up=0: if q==0, q<=mod and wrap<=1. Otherwise q<=q-1.
- Hold: if p&t=0, q holds and wrap<=0.
- co = t & (up ? q==mod : q==0).
  - Combinational from registered q, mod and the live t/up.
  - p does not affect co.
- Up-count with q>mod (after a load above the modulus): q counts through 2**WIDTH-1, rolls over to 0 with wrap=0, then terminates normally at mod.
- Changing up between edges takes effect at the next edge. co follows up immediately.

## Timing
- Load and count latency: q changes 1 cycle after the qualifying edge.
- wrap asserts in the cycle after the terminal edge and lasts exactly one cycle unless the next edge wraps again (e.g. mod=0).
- co is valid one combinational delay after cp or t/up changes.
- Cascade: co of slice n drives t of slice n+1. All slices share p, up, load_, clr and cp.
- Reset values: q=0, wrap=0, mod=MAXVAL. co after reset is t&~up (or t&up if MAXVAL==0).
- clr mid-count overrides any simultaneous load_, mload_ or count.

## Configuration
- AM25LS_MODULO_EN defined: the modulus register and mload_ are implemented as described above.
- AM25LS_MODULO_EN undefined:
  - No modulus register; mod is the constant MAXVAL.
  - mload_ is still a port but is ignored.
  - With the default MAXVAL, behaviour is a plain binary up/down counter.

## Structure
- Shared package am25ls_pkg: the direction constants DIR_UP=1 and DIR_DN=0, and the default-MAXVAL helper (all-ones of WIDTH).
- One sub-module, am25ls_tcdet. It is a combinational terminal detector producing tc_up (q==mod), tc_dn (q==0) and co. The counter core instantiates it.

## Test plan
- WIDTH=8, clr=1 for one edge with load_=0, din=0x55 -> q=0x00, wrap=0, mod=0xFF. With t=1, up=0, co=1.
- Load 0xFD, then up-count p=t=1 for 3 edges -> q=0xFE, then 0xFF (co=1), then 0x00. wrap=1 for one cycle only.
- AM25LS_MODULO_EN: mload_=0 with din=9, load 7, up-count 4 edges -> q=8, 9 (co=1), 0 (wrap=1), 1 (wrap=0).
- AM25LS_MODULO_EN, mod=9: load 1 with up=0, count 3 edges -> q=0 (co=1), then 9 (wrap=1), then 8. With t=0, co=0 throughout.
- Hold: q=0x42, p=0 t=1 for 2 edges -> q stays 0x42 and wrap=0. Then p=1 t=0 -> q still 0x42 and co=0.
- Two WIDTH=4 slices cascaded (co->t), loaded 0x0E, up-count 2 edges -> q=0x0F (low co=1), then 0x10. High slice increments only on that edge.
